irq_priority_encoder: RTL and testbench
=======================================

# irq_priority_encoder

Interrupt controller for the IO board CPLD. It collects 16 edge-triggered peripheral interrupt requests and encodes the highest-priority pending request into a Z80 mode-2 vector. It handles the INT/acknowledge/end-of-interrupt handshake with the CPU bus logic. It sits between the peripheral request lines and the Z80 INT pin, and complements the board's 4-to-16 select decoding in the opposite direction: one-hot requests in, binary index out.

## Interface
- VECTOR_BASE, 3'b000: bits [7:5] of every emitted vector.
- SYNC_STAGES, 2: synchronizer depth per request line (minimum 2).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  16  peripheral requests, asynchronous; a rising edge is one event.
- mask  in  16  1 = line enabled; synchronous to clk.
- inta  in  1  one-clk acknowledge strobe from bus logic (M1 & IORQ decoded).
- eoi  in  1  one-clk end-of-interrupt strobe (CPU write to EOI port).
- int_n  out  1  active-low interrupt to the Z80.
- vector_out  out  8  {VECTOR_BASE, id[3:0], 1'b0}; driven onto the data bus during acknowledge.
- vector_valid  out  1  high from acknowledge until EOI.
- active_id  out  4  id currently asserted or in service.
- pending  out  16  pending event register, for debug readback.

## Operation
- Reset values: int_n=1, vector_out=8'h00, vector_valid=0, active_id=0, pending=0, all sync flops=0, state IDLE.
- A line held high across reset release produces exactly one event.
- Each irq_in passes through SYNC_STAGES flops.
- A 0→1 transition at the last stage sets pending[i].
- pending[i] stays set regardless of mask until it is cleared by acknowledge.
- Candidate set = pending & mask. Priority is fixed: lowest index wins (bit 0 highest).
- FSM states:
  - IDLE:
    - candidate set nonzero → ASSERT.
    - Latch active_id = winner; int_n=0.
  - ASSERT:
    - Re-evaluate every cycle. A higher-priority candidate replaces active_id; int_n stays 0.
    - Candidate set becomes empty (masked before ack) → int_n=1, back to IDLE.
    - inta=1 → vector_out={VECTOR_BASE, active_id, 0}, vector_valid=1, int_n=1, clear pending[active_id], go to SERVICE.
  - SERVICE:
    - No new INT is asserted; nesting is not supported.
    - eoi=1 → vector_valid=0, go to IDLE. The next candidate may assert on the following cycle.
- inta in IDLE or SERVICE is ignored: no state or output change.
- eoi in IDLE or ASSERT is ignored.
- Edge-set and ack-clear on the same bit in the same cycle: set wins, so the new event is retained.
- New edges arriving during SERVICE are recorded in pending and served after EOI.
- Repeated edges on an already-pending line merge into one event.

## Timing
- All outputs are registered.
- Request latency with SYNC_STAGES=2: irq_in rises before edge k → pending set after edge k+2 → int_n low after edge k+3. In general, SYNC_STAGES+2 edges.
- inta sampled high at edge m → vector_out, vector_valid=1, int_n=1 all visible after edge m. Bus logic reads vector_out from cycle m+1 onward.
- eoi at edge n → IDLE after n. If a candidate exists, int_n goes low after edge n+1.
- Priority switch in ASSERT: active_id updates one edge after the higher-priority pending bit appears.
- vector_out holds its value through IDLE until the next acknowledge.
- Asynchronous rst mid-operation: all outputs return to reset values immediately, and pending events are lost.

## Test plan
- Single request:
  - Stimulus: irq_in[5] pulses high, with VECTOR_BASE=3'b101.
  - Response: int_n low 4 edges later, active_id=5; inta → vector_out=8'hAA, int_n=1, pending[5]=0; eoi → vector_valid=0, IDLE.
- Simultaneous requests:
  - Stimulus: irq_in[3] and irq_in[9] rise together; ack/eoi on id 3.
  - Response: id 3 is served first (vector 8'h06 with base 0); int_n reasserts after eoi with id 9 (vector 8'h12).
- Preemption before ack:
  - Stimulus: irq 12 in ASSERT, then irq 1 arrives before inta.
  - Response: active_id changes to 1; int_n stays low; inta returns vector 8'h02; pending[12] stays set.
- Masking:
  - Stimulus: irq 7 in ASSERT, then mask[7] cleared with no other candidates.
  - Response: int_n=1, IDLE, pending[7] still 1; mask[7] re-set → int_n low again.
- Edge/clear collision:
  - Stimulus: new irq_in[4] edge reaches pending on the same edge as inta for id 4.
  - Response: pending[4]=1 after that edge; served again after eoi.
- Reset and ignored strobes:
  - Stimulus: assert rst during SERVICE; also drive inta and eoi in IDLE.
  - Response: all outputs return to reset values immediately; strobes in IDLE cause no change; an irq_in held high through reset yields exactly one INT after release.

Source files
------------

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: 16-line edge-triggered interrupt controller emitting Z80 mode-2 vectors
module irq_priority_encoder #(
  parameter logic [2:0] VECTOR_BASE = 3'b000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irq_in,
  input  logic [15:0] mask,
  input  logic        inta,
  input  logic        eoi,
  output logic        int_n,
  output logic [7:0]  vector_out,
  output logic        vector_valid,
  output logic [3:0]  active_id,
  output logic [15:0] pending
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][15:0] sync;
  logic [15:0] last, edges, cand, clr, pending_n;
  logic [3:0] win;
  logic ack;
  always_comb begin
    edges = sync[SYNC_STAGES-1] & ~last;
    cand = pending & mask;
    ack = (state == ASSERT) && inta;
    clr = ack ? 16'd1 << active_id : 16'h0;
    pending_n = (pending & ~clr) | edges;
  end
  always_comb begin
    win = 4'd0;
    for (int i = 15; i >= 0; i--) if (cand[i]) win = 4'(i);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (|cand) state_n = ASSERT;
      ASSERT: if (inta) state_n = SERVICE; else if (!(|cand)) state_n = IDLE;
      SERVICE: if (eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sync <= '0;
      last <= 16'h0;
      pending <= 16'h0;
      int_n <= 1'b1;
      vector_out <= 8'h00;
      vector_valid <= 1'b0;
      active_id <= 4'd0;
    end else begin
      state <= state_n;
      sync <= {sync[SYNC_STAGES-2:0], irq_in};
      last <= sync[SYNC_STAGES-1];
      pending <= pending_n;
      int_n <= state_n != ASSERT;
      if (state_n == ASSERT) active_id <= win;
      if (ack) begin
        vector_out <= {VECTOR_BASE, active_id, 1'b0};
        vector_valid <= 1'b1;
      end else if (state == SERVICE && eoi) begin
        vector_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_irq_priority_encoder.sv
// tb_irq_priority_encoder: directed and random checks of irq_priority_encoder against a behavioural model
module tb_irq_priority_encoder;
  localparam logic [2:0] BASE = 3'b101;
  localparam int SYNC = 2;
  logic clk = 1'b0, rst = 1'b0, inta = 1'b0, eoi = 1'b0;
  logic [15:0] irq_in = 16'h0, mask = 16'hFFFF;
  logic int_n, vector_valid;
  logic [7:0] vector_out;
  logic [3:0] active_id;
  logic [15:0] pending;
  int total = 0, bad = 0;
  logic [15:0] hist[$];
  logic [15:0] m_pend;
  int m_phase;
  logic [3:0] m_id;
  logic [7:0] m_vec;
  logic m_valid;

  irq_priority_encoder #(.VECTOR_BASE(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .inta(inta), .eoi(eoi),
    .int_n(int_n), .vector_out(vector_out), .vector_valid(vector_valid),
    .active_id(active_id), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lowest(input logic [15:0] c);
    logic [15:0] one;
    one = c & (~c + 16'd1);
    for (int i = 0; i < 16; i++) if (one == (16'd1 << i)) return 4'(i);
    return 4'd0;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    hist = {};
    repeat (SYNC + 1) hist.push_back(16'h0);
    m_pend = 16'h0;
    m_phase = 0;
    m_id = 4'd0;
    m_vec = 8'h00;
    m_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] cand, ev;
    cand = m_pend & mask;
    ev = hist[SYNC-1] & ~hist[SYNC];
    if (m_phase == 0) begin
      if (cand != 16'h0) begin m_phase = 1; m_id = lowest(cand); end
    end else if (m_phase == 1) begin
      if (inta) begin
        m_vec = {BASE, m_id, 1'b0};
        m_valid = 1'b1;
        m_pend[m_id] = 1'b0;
        m_phase = 2;
      end else if (cand == 16'h0) m_phase = 0;
      else m_id = lowest(cand);
    end else if (eoi) begin
      m_valid = 1'b0;
      m_phase = 0;
    end
    m_pend = m_pend | ev;
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endtask

  task automatic check_all();
    check("int_n", 16'(int_n), 16'(m_phase != 1));
    check("vector_out", 16'(vector_out), 16'(m_vec));
    check("vector_valid", 16'(vector_valid), 16'(m_valid));
    check("active_id", 16'(active_id), 16'(m_id));
    check("pending", pending, m_pend);
  endtask

  task automatic step(input logic a, input logic e);
    inta = a;
    eoi = e;
    @(posedge clk);
    model_edge();
    #1;
    inta = 1'b0;
    eoi = 1'b0;
    check_all();
  endtask

  task automatic tick(); step(1'b0, 1'b0); endtask
  task automatic do_ack(); step(1'b1, 1'b0); endtask
  task automatic do_eoi(); step(1'b0, 1'b1); endtask

  task automatic pulse(input logic [15:0] bits);
    irq_in = bits;
    tick();
    irq_in = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_int_n", 16'(int_n), 16'h1);
    check("rst_pending", pending, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] b;
    #2 do_reset();
    pulse(16'h0020); tick(); tick();
    check("single_pend", pending, 16'h0020);
    check("single_int_n_late", 16'(int_n), 16'h1);
    tick();
    check("single_int_n", 16'(int_n), 16'h0);
    check("single_id", 16'(active_id), 16'h5);
    do_ack();
    check("single_vec", 16'(vector_out), 16'h00AA);
    check("single_ack_int_n", 16'(int_n), 16'h1);
    check("single_clr", pending, 16'h0);
    tick(); do_eoi();
    check("single_eoi_valid", 16'(vector_valid), 16'h0);
    check("vec_hold", 16'(vector_out), 16'h00AA);
    do_ack(); do_eoi();
    check("idle_strobe_vec", 16'(vector_out), 16'h00AA);
    check("idle_strobe_int_n", 16'(int_n), 16'h1);
    pulse(16'h0208); tick(); tick(); tick();
    check("simul_id3", 16'(active_id), 16'h3);
    do_ack();
    check("simul_vec3", 16'(vector_out), 16'h00A6);
    check("simul_pend9", pending, 16'h0200);
    do_eoi();
    check("simul_eoi_int_n", 16'(int_n), 16'h1);
    tick();
    check("simul_id9", 16'(active_id), 16'h9);
    check("simul_int_n9", 16'(int_n), 16'h0);
    do_ack();
    check("simul_vec9", 16'(vector_out), 16'h00B2);
    do_eoi();
    pulse(16'h1000); tick(); tick(); tick();
    check("pre_id12", 16'(active_id), 16'hC);
    pulse(16'h0002); tick(); tick();
    check("pre_still12", 16'(active_id), 16'hC);
    tick();
    check("pre_id1", 16'(active_id), 16'h1);
    check("pre_int_n", 16'(int_n), 16'h0);
    do_ack();
    check("pre_vec1", 16'(vector_out), 16'h00A2);
    check("pre_pend12", pending, 16'h1000);
    do_eoi(); tick();
    check("pre_back12", 16'(active_id), 16'hC);
    do_ack(); do_eoi();
    pulse(16'h0080); tick(); tick(); tick();
    check("mask_id7", 16'(active_id), 16'h7);
    mask = 16'hFF7F;
    tick();
    check("mask_int_n", 16'(int_n), 16'h1);
    check("mask_pend", pending, 16'h0080);
    tick();
    mask = 16'hFFFF;
    tick();
    check("unmask_int_n", 16'(int_n), 16'h0);
    do_ack(); do_eoi();
    pulse(16'h0010); tick(); tick(); tick();
    pulse(16'h0010); tick(); do_ack();
    check("coll_pend", pending, 16'h0010);
    check("coll_vec", 16'(vector_out), 16'h00A8);
    do_eoi(); tick();
    check("coll_again", 16'(int_n), 16'h0);
    do_ack();
    check("coll_clr", pending, 16'h0);
    do_eoi();
    pulse(16'h0004); tick(); tick(); tick(); do_ack();
    pulse(16'h0400); tick(); tick();
    check("svc_pend10", pending, 16'h0400);
    irq_in = 16'h0040;
    do_reset();
    check("rst_valid", 16'(vector_valid), 16'h0);
    check("rst_vec", 16'(vector_out), 16'h00);
    tick(); tick(); tick();
    check("held_int_n_late", 16'(int_n), 16'h1);
    tick();
    check("held_id6", 16'(active_id), 16'h6);
    do_ack(); do_eoi();
    repeat (6) tick();
    check("held_once", 16'(int_n), 16'h1);
    irq_in = 16'h0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        b = 4'($urandom_range(0, 15));
        irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(0, 24) == 0) mask = 16'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
